// File: rtl/bram_sp_be_pipe_pkg.sv
// ---------------------------------------------------------------------------
// bram_pkg
// Shared definitions for the single-port byte-enable block RAM:
//   - read-during-write mode selectors (READ_FIRST / WRITE_FIRST / NO_CHANGE)
//   - clear sequencer state encoding (IDLE / CLEAR)
//   - bram_merge_be(): byte-wise merge of a new word over an old word
// No ports; imported by bram_sp_be_pipe and bram_rd_pipe.
// ---------------------------------------------------------------------------
package bram_pkg;

  // Read-during-write behaviour when a write and a read hit the same word
  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;
  localparam int RDW_NO_CHANGE   = 2;

  // Widest word the merge helper handles; callers size-cast in and out
  localparam int MERGE_MAX_W = 256;

  // Clear sequencer states
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clrState_t;

  // Returns oldWord with every byte i replaced by newWord byte i where be[i]=1.
  // Fixed at MERGE_MAX_W so one function serves every DATA_W instance.
  function automatic logic [MERGE_MAX_W-1:0] bram_merge_be(
    input logic [MERGE_MAX_W-1:0]   oldWord,
    input logic [MERGE_MAX_W-1:0]   newWord,
    input logic [MERGE_MAX_W/8-1:0] be
  );
    logic [MERGE_MAX_W-1:0] merged;
    merged = oldWord;
    for (int i = 0; i < MERGE_MAX_W/8; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = newWord[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/bram_sp_be_pipe_rd_pipe.sv
// ---------------------------------------------------------------------------
// bram_rd_pipe
// Delay line for read data plus its valid flag. Each stage only reloads its
// data when the stage before it is valid, so the last stage holds the most
// recent read result while no new read is flowing through.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_data, i_vld    data/valid entering the delay line
//   o_data, o_vld    data/valid after LAT clocks
// Parameters: W (data width), LAT (number of stages, >=1), RST_VAL.
// ---------------------------------------------------------------------------
module bram_rd_pipe
  import bram_pkg::*;
#(
  parameter int           W       = 16,
  parameter int           LAT     = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_data,
  input  logic         i_vld,
  output logic [W-1:0] o_data,
  output logic         o_vld
);

  logic [W-1:0]   r_data [LAT];
  logic [LAT-1:0] r_vld;

  // Shift valid every cycle; data advances only behind a valid so that the
  // output stage keeps its last result between reads.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < LAT; k++) begin
        r_data[k] <= RST_VAL;
      end
      r_vld <= '0;
    end else begin
      r_vld[0] <= i_vld;
      if (i_vld) begin
        r_data[0] <= i_data;
      end
      for (int k = 1; k < LAT; k++) begin
        r_vld[k] <= r_vld[k-1];
        if (r_vld[k-1]) begin
          r_data[k] <= r_data[k-1];
        end
      end
    end
  end

  assign o_data = r_data[LAT-1];
  assign o_vld  = r_vld[LAT-1];

endmodule

// File: rtl/bram_sp_be_pipe.sv
// ---------------------------------------------------------------------------
// bram_sp_be_pipe
// Single-port block RAM with per-byte write enables, selectable
// read-during-write mode, a read pipeline of RD_LAT clocks and a built-in
// clear sequencer that zeroes the array after reset or on request.
// Ports:
//   i_clk        clock
//   i_rst        synchronous, active-high reset
//   i_en         access enable
//   i_we         write enable (qualified by i_en)
//   i_be         byte write enables, bit i covers i_di[8i+7:8i]
//   i_addr       word address
//   i_di         write data
//   i_clrReq     one-cycle pulse requesting a full array clear
//   o_dout       read data (held while o_doutVld is low)
//   o_doutVld    one-cycle pulse: o_dout holds a read result
//   o_busy       clear in progress, user accesses are dropped
// ---------------------------------------------------------------------------
module bram_sp_be_pipe
  import bram_pkg::*;
#(
  parameter int                DATA_W     = 16,
  parameter int                ADDR_W     = 10,
  parameter int                DEPTH      = 1 << ADDR_W,
  parameter int                BE_W       = DATA_W / 8,
  parameter int                RD_LAT     = 1,
  parameter int                RDW_MODE   = 0,
  parameter logic [DATA_W-1:0] RST_VAL    = '0,
  parameter int                CLR_ON_RST = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [BE_W-1:0]   i_be,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_di,
  input  logic              i_clrReq,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_doutVld,
  output logic              o_busy
);

  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [BE_W-1:0]   BE_ALL    = '1;

  // Storage array, left without reset so it maps onto block RAM
  logic [DATA_W-1:0] r_mem [DEPTH];

  // Clear sequencer
  clrState_t         r_state;
  logic [ADDR_W-1:0] r_clrAddr;

  // Stage-1 read register and the side information needed to finish it
  logic [DATA_W-1:0] r_ramQ;
  logic              r_s1Vld;
  logic              r_s1Oob;
  logic              r_s1Merge;
  logic [DATA_W-1:0] r_s1Di;
  logic [BE_W-1:0]   r_s1Be;

  logic              w_busy;
  logic              w_clrStart;
  logic              w_issue;
  logic              w_inRange;
  logic              w_userWr;
  logic              w_userRd;
  logic              w_clrWr;
  logic              w_memWe;
  logic [ADDR_W-1:0] w_memAddr;
  logic [DATA_W-1:0] w_memDi;
  logic [BE_W-1:0]   w_memBe;
  logic [DATA_W-1:0] w_s1Data;

  // A clear starting this cycle beats any user access presented with it.
  // Nothing is issued on a reset edge, so rst never touches the array.
  assign w_busy     = (r_state == CLEAR);
  assign w_clrStart = !i_rst && (r_state == IDLE) && i_clrReq;
  assign w_issue    = !i_rst && i_en && !w_busy && !w_clrStart;
  assign w_inRange  = ({1'b0, i_addr} < DEPTH_EXT);
  assign w_userWr   = w_issue && i_we && w_inRange;
  assign w_userRd   = w_issue && !(i_we && (RDW_MODE == RDW_NO_CHANGE));
  assign w_clrWr    = !i_rst && w_busy;

  // One shared write port: the clear sequencer owns it while busy.
  assign w_memWe   = w_clrWr || w_userWr;
  assign w_memAddr = w_clrWr ? r_clrAddr : i_addr;
  assign w_memDi   = w_clrWr ? '0 : i_di;
  assign w_memBe   = w_clrWr ? BE_ALL : i_be;

  // Byte-enabled write into the array
  always_ff @(posedge i_clk) begin
    if (w_memWe) begin
      for (int i = 0; i < BE_W; i++) begin
        if (w_memBe[i]) begin
          r_mem[w_memAddr][8*i +: 8] <= w_memDi[8*i +: 8];
        end
      end
    end
  end

  // Synchronous read, naturally read-first; write-first is produced later by
  // merging the captured write data over this old word.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ramQ <= RST_VAL;
    end else if (w_userRd) begin
      r_ramQ <= r_mem[i_addr];
    end
  end

  // Side information travelling with the stage-1 read. Everything except the
  // valid only reloads on a read so the stage-1 result holds between reads.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1Vld   <= 1'b0;
      r_s1Oob   <= 1'b0;
      r_s1Merge <= 1'b0;
      r_s1Di    <= '0;
      r_s1Be    <= '0;
    end else begin
      r_s1Vld <= w_userRd;
      if (w_userRd) begin
        r_s1Oob   <= !w_inRange;
        r_s1Merge <= (RDW_MODE == RDW_WRITE_FIRST) && i_we;
        r_s1Di    <= i_di;
        r_s1Be    <= i_be;
      end
    end
  end

  // Finish the stage-1 word: out-of-range reads return zero, write-first
  // reads see the new bytes over the old word.
  always_comb begin
    w_s1Data = r_ramQ;
    if (r_s1Merge) begin
      w_s1Data = DATA_W'(bram_merge_be(MERGE_MAX_W'(r_ramQ),
                                       MERGE_MAX_W'(r_s1Di),
                                       (MERGE_MAX_W/8)'(r_s1Be)));
    end
    if (r_s1Oob) begin
      w_s1Data = '0;
    end
  end

  // Clear sequencer: DEPTH cycles in CLEAR, one word zeroed per cycle.
  // Requests arriving while already clearing are ignored.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= (CLR_ON_RST != 0) ? CLEAR : IDLE;
      r_clrAddr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_clrReq) begin
            r_state   <= CLEAR;
            r_clrAddr <= '0;
          end
        end
        CLEAR: begin
          if (r_clrAddr == LAST_ADDR) begin
            r_state   <= IDLE;
            r_clrAddr <= '0;
          end else begin
            r_clrAddr <= r_clrAddr + 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_clrAddr <= '0;
        end
      endcase
    end
  end

  assign o_busy = w_busy;

  // Remaining RD_LAT-1 stages, or straight out of stage 1 when RD_LAT is 1
  generate
    if (RD_LAT == 1) begin : g_lat1
      assign o_dout    = w_s1Data;
      assign o_doutVld = r_s1Vld;
    end else begin : g_latN
      bram_rd_pipe #(
        .W       (DATA_W),
        .LAT     (RD_LAT - 1),
        .RST_VAL (RST_VAL)
      ) u_rdPipe (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_data (w_s1Data),
        .i_vld  (r_s1Vld),
        .o_data (o_dout),
        .o_vld  (o_doutVld)
      );
    end
  endgenerate

endmodule
